// File: rtl/addr_offset_gen_pkg.sv
// Shared encodings and sizing helpers for the convolution address generator.
package addr_offset_gen_pkg;

  typedef enum logic [1:0] {
    OFS_FILTER = 2'b00,
    OFS_WRITE  = 2'b01,
    OFS_LINE   = 2'b10,
    OFS_RSVD   = 2'b11
  } ofs_mode_e;

  typedef enum logic [1:0] {
    BASE_X    = 2'b00,
    BASE_Y    = 2'b01,
    BASE_Z    = 2'b10,
    BASE_ZERO = 2'b11
  } base_sel_e;

  // Counter widths never collapse to zero bits, even for single-word bursts.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/addr_offset_gen_if.sv
// Controller <-> address generator bus; the controller drives the master side.
interface addr_offset_gen_if #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 4
);
  logic              offset_rst;
  logic              offset_active;
  logic [1:0]        offset_mode;
  logic [1:0]        base_addr_sel;
  logic [ADDR_W-1:0] base_x;
  logic [ADDR_W-1:0] base_y;
  logic [ADDR_W-1:0] base_z;
  logic [ADDR_W-1:0] mem_addr;
  logic              offset_done;
  logic [IDX_W-1:0]  line_idx;

  modport master (
    output offset_rst, offset_active, offset_mode, base_addr_sel,
           base_x, base_y, base_z,
    input  mem_addr, offset_done, line_idx
  );

  modport slave (
    input  offset_rst, offset_active, offset_mode, base_addr_sel,
           base_x, base_y, base_z,
    output mem_addr, offset_done, line_idx
  );
endinterface

// File: rtl/addr_offset_gen_counter.sv
// Wrapping up-counter; restart_i makes this cycle behave as if the count were 0.
module offset_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             restart_i,
  input  logic [WIDTH-1:0] terminal_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;

  assign count_o = restart_i ? '0 : count_q;
  assign tc_o    = (count_o == terminal_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= tc_o ? '0 : count_o + 1'b1;
    end
  end

endmodule

// File: rtl/addr_offset_gen.sv
// Memory address generator: mem_addr = base + pointer + burst offset, with
// persistent line and result pointers walking the image and output areas.
module addr_offset_gen
  import addr_offset_gen_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int FILTER_WORDS = 16,
  parameter int LINE_WORDS   = 16,
  parameter int IMG_LINES    = 16,
  parameter int WR_WORDS     = 1
) (
  input logic               clk,
  input logic               rst,
  addr_offset_gen_if.slave  bus
);

  localparam int CNT_W = clog2_min1(max3(FILTER_WORDS, LINE_WORDS, WR_WORDS));
  localparam int IDX_W = clog2_min1(IMG_LINES);
  localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(LINE_WORDS);
  localparam logic [ADDR_W-1:0] WR_STRIDE   = ADDR_W'(WR_WORDS);

  logic [1:0]        last_mode_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0]  cnt_eff;
  logic [CNT_W-1:0]  burst_term;
  logic [IDX_W-1:0]  line_ptr;
  logic              burst_tc;
  logic              line_tc_unused;
  logic              mode_rsvd;
  logic              mode_chg;
  logic              done;
  logic              line_adv;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] ofs_sum;

  assign mode_rsvd = (bus.offset_mode == OFS_RSVD);
  assign mode_chg  = (bus.offset_mode != last_mode_q);
  assign done      = bus.offset_active & ~mode_rsvd & burst_tc;
  assign line_adv  = done & (bus.offset_mode == OFS_LINE);

  always_comb begin
    burst_term = '0;
    case (bus.offset_mode)
      OFS_FILTER: burst_term = CNT_W'(FILTER_WORDS - 1);
      OFS_LINE:   burst_term = CNT_W'(LINE_WORDS - 1);
      OFS_WRITE:  burst_term = CNT_W'(WR_WORDS - 1);
      default:    burst_term = '0;
    endcase
  end

  // Idle and reserved cycles clear the burst so an aborted burst restarts at 0.
  offset_counter #(.WIDTH(CNT_W)) u_burst_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (bus.offset_rst | ~bus.offset_active | mode_rsvd),
    .enable_i   (bus.offset_active & ~mode_rsvd),
    .restart_i  (mode_chg),
    .terminal_i (burst_term),
    .count_o    (cnt_eff),
    .tc_o       (burst_tc)
  );

  offset_counter #(.WIDTH(IDX_W)) u_line_ptr (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (bus.offset_rst),
    .enable_i   (line_adv),
    .restart_i  (1'b0),
    .terminal_i (IDX_W'(IMG_LINES - 1)),
    .count_o    (line_ptr),
    .tc_o       (line_tc_unused)
  );

  always_comb begin
    base = '0;
    case (bus.base_addr_sel)
      BASE_X:  base = bus.base_x;
      BASE_Y:  base = bus.base_y;
      BASE_Z:  base = bus.base_z;
      default: base = '0;
    endcase
  end

  always_comb begin
    ofs_sum = '0;
    case (bus.offset_mode)
      OFS_FILTER: ofs_sum = ADDR_W'(cnt_eff);
      OFS_LINE:   ofs_sum = ADDR_W'(line_ptr) * LINE_STRIDE + ADDR_W'(cnt_eff);
      OFS_WRITE:  ofs_sum = wr_ptr_q + ADDR_W'(cnt_eff);
      default:    ofs_sum = '0;
    endcase
  end

  // Async reset forces the outputs low immediately, not at the next edge.
  assign bus.mem_addr    = rst ? '0 : base + ofs_sum;
  assign bus.offset_done = rst ? 1'b0 : done;
  assign bus.line_idx    = line_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_mode_q <= OFS_FILTER;
      wr_ptr_q    <= '0;
    end else if (bus.offset_rst) begin
      last_mode_q <= OFS_FILTER;
      wr_ptr_q    <= '0;
    end else if (bus.offset_active) begin
      last_mode_q <= bus.offset_mode;
      if (done && (bus.offset_mode == OFS_WRITE)) begin
        wr_ptr_q <= wr_ptr_q + WR_STRIDE;
      end
    end
  end

endmodule
